// File: rtl/freelist_2a2f_pkg.sv
// rtl/freelist_2a2f_pkg.sv - shared constants, count-width helper and FSM encoding for freelist_2a2f
package freelist_2a2f_pkg;

  localparam int DEFAULT_TAG_WIDTH = 6;
  localparam int DEFAULT_DEPTH     = 64;

  // Occupancy must represent 0..DEPTH inclusive, hence one extra bit.
  function automatic int count_width(input int tag_width);
    return tag_width + 1;
  endfunction

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

endpackage

// File: rtl/freelist_2a2f_if.sv
// rtl/freelist_2a2f_if.sv - rename/commit handshake bundle for the physical-tag free list
//
// Signals:
//   alloc_req1/alloc_req2 : rename requests one or two tags
//   alloc_ok              : request granted this cycle (combinational)
//   alloc_tag1/alloc_tag2 : tags at head and head+1 (combinational)
//   free_we1/free_we2     : commit returns tags
//   free_tag1/free_tag2   : returned tag values
//   ready                 : init sequence done
//   freecnt               : registered occupancy
//   err                   : sticky overflow flag
// Modports: master = rename/commit side, slave = free list.
interface freelist_2a2f_if
  import freelist_2a2f_pkg::*;
#(
  parameter int TAG_WIDTH = DEFAULT_TAG_WIDTH
) ();

  logic                               alloc_req1;
  logic                               alloc_req2;
  logic                               alloc_ok;
  logic [TAG_WIDTH-1:0]               alloc_tag1;
  logic [TAG_WIDTH-1:0]               alloc_tag2;
  logic                               free_we1;
  logic                               free_we2;
  logic [TAG_WIDTH-1:0]               free_tag1;
  logic [TAG_WIDTH-1:0]               free_tag2;
  logic                               ready;
  logic [count_width(TAG_WIDTH)-1:0]  freecnt;
  logic                               err;

  modport master (
    output alloc_req1, alloc_req2, free_we1, free_we2, free_tag1, free_tag2,
    input  alloc_ok, alloc_tag1, alloc_tag2, ready, freecnt, err
  );

  modport slave (
    input  alloc_req1, alloc_req2, free_we1, free_we2, free_tag1, free_tag2,
    output alloc_ok, alloc_tag1, alloc_tag2, ready, freecnt, err
  );

endinterface

// File: rtl/freelist_2a2f_ram.sv
// rtl/freelist_2a2f_ram.sv - 2-read/2-write storage, asynchronous read, synchronous write
//
// Ports:
//   clk                     : write clock
//   we1/waddr1/wdata1       : write port 1
//   we2/waddr2/wdata2       : write port 2 (applied after port 1 on an address clash)
//   raddr1/rdata1           : asynchronous read port 1
//   raddr2/rdata2           : asynchronous read port 2
module ram_sync_nolatch_2r2w #(
  parameter int BRAM_ADDR_WIDTH = 6,
  parameter int BRAM_DATA_WIDTH = 6,
  parameter int DATA_DEPTH      = 64
) (
  input  logic                       clk,
  input  logic                       we1,
  input  logic [BRAM_ADDR_WIDTH-1:0] waddr1,
  input  logic [BRAM_DATA_WIDTH-1:0] wdata1,
  input  logic                       we2,
  input  logic [BRAM_ADDR_WIDTH-1:0] waddr2,
  input  logic [BRAM_DATA_WIDTH-1:0] wdata2,
  input  logic [BRAM_ADDR_WIDTH-1:0] raddr1,
  output logic [BRAM_DATA_WIDTH-1:0] rdata1,
  input  logic [BRAM_ADDR_WIDTH-1:0] raddr2,
  output logic [BRAM_DATA_WIDTH-1:0] rdata2
);

  logic [BRAM_DATA_WIDTH-1:0] mem [DATA_DEPTH];

  always_ff @(posedge clk) begin
    if (we1) mem[waddr1] <= wdata1;
    if (we2) mem[waddr2] <= wdata2;
  end

  assign rdata1 = mem[raddr1];
  assign rdata2 = mem[raddr2];

endmodule

// File: rtl/freelist_2a2f.sv
// rtl/freelist_2a2f.sv - physical-tag free list: two allocs and two frees per cycle
//
// Ports:
//   clk     : clock, all state updates on the rising edge
//   reset_n : asynchronous active-low reset
//   bus     : freelist_2a2f_if.slave (alloc/free handshake, ready, freecnt, err)
//
// Optional feature: define FREELIST_ERRCHK_EN to build the sticky overflow
// checker driving err; otherwise err is tied low.
module freelist_2a2f
  import freelist_2a2f_pkg::*;
#(
  parameter int TAG_WIDTH = DEFAULT_TAG_WIDTH,
  parameter int DEPTH     = DEFAULT_DEPTH
) (
  input  logic             clk,
  input  logic             reset_n,
  freelist_2a2f_if.slave   bus
);

  localparam int CW = count_width(TAG_WIDTH);

  state_e               state;
  logic [TAG_WIDTH-1:0] init_ptr;
  logic [TAG_WIDTH-1:0] head;
  logic [TAG_WIDTH-1:0] tail;
  logic [CW-1:0]        count;

  logic [1:0]           nreq;
  logic [1:0]           nfree;
  logic [1:0]           ngrant;
  logic                 ready;
  logic                 alloc_ok;
  logic [CW-1:0]        count_next;

  logic                 ram_we1, ram_we2;
  logic [TAG_WIDTH-1:0] ram_waddr1, ram_waddr2;
  logic [TAG_WIDTH-1:0] ram_wdata1, ram_wdata2;

  assign ready = (state == ST_RUN);

  always_comb begin
    nreq       = {1'b0, bus.alloc_req1} + {1'b0, bus.alloc_req1 & bus.alloc_req2};
    nfree      = {1'b0, bus.free_we1} + {1'b0, bus.free_we2};
    // All-or-nothing grant: never hand out one tag when two were asked for.
    alloc_ok   = ready && (nreq != 2'd0) && (count >= CW'(nreq));
    ngrant     = alloc_ok ? nreq : 2'd0;
    count_next = count + CW'(nfree) - CW'(ngrant);
  end

  // Write-port steering: the init sequencer owns both ports until RUN.
  // A lone free on either port lands at tail through RAM port 1 so the
  // queue never gets a hole.
  always_comb begin
    ram_we1    = 1'b0;
    ram_we2    = 1'b0;
    ram_waddr1 = tail;
    ram_waddr2 = tail + TAG_WIDTH'(1);
    ram_wdata1 = bus.free_tag1;
    ram_wdata2 = bus.free_tag2;
    if (state == ST_INIT) begin
      ram_we1    = 1'b1;
      ram_we2    = 1'b1;
      ram_waddr1 = init_ptr;
      ram_waddr2 = init_ptr + TAG_WIDTH'(1);
      ram_wdata1 = init_ptr;
      ram_wdata2 = init_ptr + TAG_WIDTH'(1);
    end else begin
      ram_we1    = bus.free_we1 | bus.free_we2;
      ram_we2    = bus.free_we1 & bus.free_we2;
      ram_wdata1 = bus.free_we1 ? bus.free_tag1 : bus.free_tag2;
    end
  end

  ram_sync_nolatch_2r2w #(
    .BRAM_ADDR_WIDTH (TAG_WIDTH),
    .BRAM_DATA_WIDTH (TAG_WIDTH),
    .DATA_DEPTH      (DEPTH)
  ) u_ram (
    .clk    (clk),
    .we1    (ram_we1),
    .waddr1 (ram_waddr1),
    .wdata1 (ram_wdata1),
    .we2    (ram_we2),
    .waddr2 (ram_waddr2),
    .wdata2 (ram_wdata2),
    .raddr1 (head),
    .rdata1 (bus.alloc_tag1),
    .raddr2 (head + TAG_WIDTH'(1)),
    .rdata2 (bus.alloc_tag2)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ST_INIT;
      init_ptr <= '0;
      head     <= '0;
      tail     <= '0;
      count    <= '0;
    end else begin
      case (state)
        ST_INIT: begin
          init_ptr <= init_ptr + TAG_WIDTH'(2);
          if (init_ptr == TAG_WIDTH'(DEPTH - 2)) begin
            state <= ST_RUN;
            head  <= '0;
            tail  <= '0;
            count <= CW'(DEPTH);
          end
        end
        ST_RUN: begin
          head  <= head + TAG_WIDTH'(ngrant);
          tail  <= tail + TAG_WIDTH'(nfree);
          count <= count_next;
        end
        default: state <= ST_INIT;
      endcase
    end
  end

`ifdef FREELIST_ERRCHK_EN
  logic err_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_q <= 1'b0;
    end else if (((state == ST_INIT) && (bus.free_we1 || bus.free_we2)) ||
                 ((state == ST_RUN) && (count_next > CW'(DEPTH)))) begin
      err_q <= 1'b1;
    end
  end

  assign bus.err = err_q;
`else
  assign bus.err = 1'b0;
`endif

  assign bus.ready    = ready;
  assign bus.alloc_ok = alloc_ok;
  assign bus.freecnt  = count;

endmodule

// File: tb/tb_freelist_2a2f.sv
// tb/tb_freelist_2a2f.sv - table-driven self-checking bench for freelist_2a2f
module tb_freelist_2a2f;
  import freelist_2a2f_pkg::*;

  localparam int TW    = 6;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  freelist_2a2f_if #(.TAG_WIDTH(TW)) bus ();

  freelist_2a2f #(.TAG_WIDTH(TW), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string         name;
    logic          r1, r2, w1, w2;
    logic [TW-1:0] t1, t2;
    logic          ok;
    logic          chk_tags;
    logic [TW-1:0] e1, e2;
    logic [TW:0]   cnt;
  } vec_t;

  vec_t vq[$];
  int tests = 0;
  int fails = 0;

  function automatic vec_t mk(input string name, input logic r1, input logic r2,
                              input logic w1, input logic w2, input int t1, input int t2,
                              input logic ok, input logic chk_tags, input int e1,
                              input int e2, input int cnt);
    vec_t v;
    v.name = name; v.r1 = r1; v.r2 = r2; v.w1 = w1; v.w2 = w2;
    v.t1 = TW'(t1); v.t2 = TW'(t2); v.ok = ok; v.chk_tags = chk_tags;
    v.e1 = TW'(e1); v.e2 = TW'(e2); v.cnt = (TW+1)'(cnt);
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input logic r1, input logic r2, input logic w1, input logic w2,
                       input logic [TW-1:0] t1, input logic [TW-1:0] t2);
    bus.alloc_req1 = r1;
    bus.alloc_req2 = r2;
    bus.free_we1   = w1;
    bus.free_we2   = w2;
    bus.free_tag1  = t1;
    bus.free_tag2  = t2;
  endtask

  task automatic apply(input vec_t v);
    drive(v.r1, v.r2, v.w1, v.w2, v.t1, v.t2);
    #1;
    chk({v.name, ".alloc_ok"}, 32'(bus.alloc_ok), 32'(v.ok));
    if (v.chk_tags) begin
      chk({v.name, ".tag1"}, 32'(bus.alloc_tag1), 32'(v.e1));
      chk({v.name, ".tag2"}, 32'(bus.alloc_tag2), 32'(v.e2));
    end
    @(posedge clk);
    #1;
    chk({v.name, ".freecnt"}, 32'(bus.freecnt), 32'(v.cnt));
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (bus.ready !== 1'b1 && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic exp_err;
`ifdef FREELIST_ERRCHK_EN
    exp_err = 1'b1;
`else
    exp_err = 1'b0;
`endif

    // Post-init traffic: hand-computed tag values and occupancy.
    vq.push_back(mk("alloc2_a", 1, 1, 0, 0, 0, 0, 1, 1, 0, 1, 62));
    vq.push_back(mk("alloc2_b", 1, 1, 0, 0, 0, 0, 1, 1, 2, 3, 60));
    for (int i = 0; i < 30; i++)
      vq.push_back(mk("drain", 1, 1, 0, 0, 0, 0, 1, 1, 4 + 2*i, 5 + 2*i, 58 - 2*i));
    vq.push_back(mk("empty_req1",     1, 0, 0, 0, 0,  0,  0, 1, 0,  1, 0));
    vq.push_back(mk("empty_free_req", 1, 0, 1, 1, 5,  9,  0, 1, 0,  1, 2));
    vq.push_back(mk("idle_show",      0, 0, 0, 0, 0,  0,  0, 1, 5,  9, 2));
    vq.push_back(mk("alloc1",         1, 0, 0, 0, 0,  0,  1, 1, 5,  9, 1));
    vq.push_back(mk("partial2_free",  1, 1, 1, 1, 7,  8,  0, 1, 9,  2, 3));
    vq.push_back(mk("alloc2_after",   1, 1, 0, 0, 0,  0,  1, 1, 9,  7, 1));
    vq.push_back(mk("alloc1_free2",   1, 0, 0, 1, 11, 20, 1, 1, 8,  4, 1));
    vq.push_back(mk("alloc1_b",       1, 0, 0, 0, 0,  0,  1, 1, 20, 5, 0));
    vq.push_back(mk("free1only",      0, 0, 1, 0, 33, 0,  0, 1, 5,  6, 1));
    vq.push_back(mk("req2_cnt1",      1, 1, 0, 0, 0,  0,  0, 1, 33, 6, 1));
    vq.push_back(mk("req2_only",      0, 1, 0, 0, 0,  0,  0, 1, 33, 6, 1));
    for (int i = 0; i < 31; i++)
      vq.push_back(mk("fill2", 0, 0, 1, 1, i, i + 31, 0, 0, 0, 0, 3 + 2*i));
    vq.push_back(mk("fill1", 0, 0, 1, 0, 40, 0, 0, 0, 0, 0, 64));

    // Reset state, with a request pending.
    drive(1, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("rst.ready",    32'(bus.ready),    0);
    chk("rst.alloc_ok", 32'(bus.alloc_ok), 0);
    chk("rst.freecnt",  32'(bus.freecnt),  0);
    chk("rst.err",      32'(bus.err),      0);

    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    wait_ready(n);
    chk("init.edges",   32'(n),              32);
    chk("init.freecnt", 32'(bus.freecnt),    64);
    chk("init.tag1",    32'(bus.alloc_tag1), 0);
    chk("init.tag2",    32'(bus.alloc_tag2), 1);

    for (int i = 0; i < vq.size(); i++) apply(vq[i]);

    // Full list: one more free overflows.
    drive(0, 0, 0, 0, 0, 0);
    #1;
    chk("full.err_before", 32'(bus.err), 0);
    drive(0, 0, 1, 0, 50, 0);
    @(posedge clk);
    #1;
    chk("overflow.err", 32'(bus.err), 32'(exp_err));
    drive(0, 0, 0, 0, 0, 0);

    // Asynchronous reset mid-RUN forces reset values immediately.
    reset_n = 1'b0;
    #1;
    chk("rst_run.ready",   32'(bus.ready),   0);
    chk("rst_run.freecnt", 32'(bus.freecnt), 0);
    chk("rst_run.err",     32'(bus.err),     0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    drive(1, 0, 0, 0, 0, 0);
    repeat (10) @(posedge clk);
    #1;
    chk("mid_init.ready",    32'(bus.ready),    0);
    chk("mid_init.alloc_ok", 32'(bus.alloc_ok), 0);

    // Reset at INIT cycle 10, then the full init sequence must restart.
    reset_n = 1'b0;
    #1;
    chk("rst_init.ready",    32'(bus.ready),    0);
    chk("rst_init.alloc_ok", 32'(bus.alloc_ok), 0);
    chk("rst_init.freecnt",  32'(bus.freecnt),  0);
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0);
    reset_n = 1'b1;
    wait_ready(n);
    chk("reinit.edges",   32'(n),              32);
    chk("reinit.freecnt", 32'(bus.freecnt),    64);
    chk("reinit.tag1",    32'(bus.alloc_tag1), 0);
    chk("reinit.tag2",    32'(bus.alloc_tag2), 1);
    chk("reinit.err",     32'(bus.err),        0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
